// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM ramp controller and the PWM datapath.
package pwm_pkg;

   localparam int PWM_DUTY_W    = 4;
   localparam int PWM_DUTY_MAX  = 10;
   localparam int PWM_DUTY_INIT = 5;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WAIT_TICK   = 2'd1,
      WAIT_PERIOD = 2'd2,
      DONE        = 2'd3
   } ramp_state_e;

endpackage

// File: rtl/pwm_rate_timer.sv
// Down-counting step-rate timer: loaded with the step rate, counts down
// while enabled and flags the last cycle of the wait.
module pwm_rate_timer #(
   parameter int RATE_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic [RATE_W-1:0] loadVal_i,
   input  logic              dec_i,
   output logic              expire_o
);

   logic [RATE_W-1:0] count_q;
   logic [RATE_W-1:0] count_d;

   // Load takes priority over decrement; the count never underflows below zero.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = loadVal_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - RATE_W'(1);
      end
   end

   // Count register, cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expire_o = (count_q == RATE_W'(1));

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramp controller: walks the applied PWM duty one step at a time toward a
// requested target, at most one step per PWM period and no faster than the
// requested step rate.
module pwm_ramp_ctrl #(
   parameter int DUTY_W    = pwm_pkg::PWM_DUTY_W,
   parameter int DUTY_MAX  = pwm_pkg::PWM_DUTY_MAX,
   parameter int DUTY_INIT = pwm_pkg::PWM_DUTY_INIT,
   parameter int RATE_W    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DUTY_W-1:0] req_target,
   input  logic [RATE_W-1:0] req_rate,
   input  logic              abort,
   input  logic              period_end,
   output logic [DUTY_W-1:0] duty_out,
   output logic              busy,
   output logic              done,
   output logic              err
);

   import pwm_pkg::*;

   localparam logic [DUTY_W-1:0] MaxDuty  = DUTY_W'(DUTY_MAX);
   localparam logic [DUTY_W-1:0] InitDuty = DUTY_W'(DUTY_INIT);
   localparam logic [DUTY_W-1:0] OneDuty  = DUTY_W'(1);

   ramp_state_e       state_q, state_d;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic [DUTY_W-1:0] tgt_q, tgt_d;
   logic [RATE_W-1:0] rate_q, rate_d;
   logic              err_q, err_d;
   logic              readyEn_q;

   logic              handshake;
   logic              overRange;
   logic [DUTY_W-1:0] clampedTgt;
   logic [DUTY_W-1:0] steppedDuty;
   logic              timerLoad;
   logic [RATE_W-1:0] timerLoadVal;
   logic              timerDec;
   logic              timerExpire;

   pwm_rate_timer #(
      .RATE_W (RATE_W)
   ) u_rate_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (timerLoad),
      .loadVal_i (timerLoadVal),
      .dec_i     (timerDec),
      .expire_o  (timerExpire)
   );

   assign handshake  = req_valid && req_ready;
   assign overRange  = (req_target > MaxDuty);
   assign clampedTgt = overRange ? MaxDuty : req_target;

   // One-step-toward-target duty; the target is clamped so this stays in range.
   always_comb begin
      steppedDuty = duty_q;
      if (duty_q < tgt_q) begin
         steppedDuty = duty_q + OneDuty;
      end else if (duty_q > tgt_q) begin
         steppedDuty = duty_q - OneDuty;
      end
   end

   // Next-state logic: request intake, rate wait, period-aligned stepping and abort.
   always_comb begin
      state_d      = state_q;
      duty_d       = duty_q;
      tgt_d        = tgt_q;
      rate_d       = rate_q;
      err_d        = 1'b0;
      timerLoad    = 1'b0;
      timerLoadVal = rate_q;
      timerDec     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (handshake) begin
               tgt_d  = clampedTgt;
               rate_d = req_rate;
               err_d  = overRange;
               if (clampedTgt == duty_q) begin
                  state_d = DONE;
               end else if (req_rate == '0) begin
                  state_d = WAIT_PERIOD;
               end else begin
                  state_d      = WAIT_TICK;
                  timerLoad    = 1'b1;
                  timerLoadVal = req_rate;
               end
            end
         end
         WAIT_TICK: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               timerDec = 1'b1;
               if (timerExpire) begin
                  state_d = WAIT_PERIOD;
               end
            end
         end
         WAIT_PERIOD: begin
            if (abort) begin
               state_d = IDLE;
            end else if (period_end) begin
               duty_d = steppedDuty;
               if (steppedDuty == tgt_q) begin
                  state_d = DONE;
               end else if (rate_q == '0) begin
                  state_d = WAIT_PERIOD;
               end else begin
                  state_d   = WAIT_TICK;
                  timerLoad = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; readyEn_q holds off req_ready until the first edge after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         duty_q    <= InitDuty;
         tgt_q     <= InitDuty;
         rate_q    <= '0;
         err_q     <= 1'b0;
         readyEn_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         duty_q    <= duty_d;
         tgt_q     <= tgt_d;
         rate_q    <= rate_d;
         err_q     <= err_d;
         readyEn_q <= 1'b1;
      end
   end

   assign req_ready = readyEn_q && (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign err       = err_q;
   assign duty_out  = duty_q;

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 Parameter DUTY_W, default 4: duty value width.
REQ-002 Parameter DUTY_MAX, default 10: highest legal duty (10 = 100 %).
REQ-003 Parameter DUTY_INIT, default 5: duty applied after reset (50 %).
REQ-004 Parameter RATE_W, default 8: width of the step-rate field.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 req_valid  input  1  new ramp request present.
REQ-008 req_ready  output  1  controller can accept a request.
REQ-009 req_target  input  DUTY_W  requested final duty.
REQ-010 req_rate  input  RATE_W  minimum clocks between duty steps.
REQ-011 abort  input  1  cancel the ramp in progress.
REQ-012 period_end  input  1  one-cycle pulse from the PWM counter at period wrap.
REQ-013 duty_out  output  DUTY_W  duty currently applied to the PWM datapath.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 done  output  1  one-cycle pulse when a ramp reaches target.
REQ-016 err  output  1  one-cycle pulse when a request target exceeds DUTY_MAX.

Function
REQ-017 FSM states SHALL be IDLE, WAIT_TICK, WAIT_PERIOD and DONE, all registered.
REQ-018 req_ready SHALL be 1 only in IDLE; a handshake is req_valid && req_ready on a rising edge.
REQ-019 On handshake the controller SHALL latch tgt = min(req_target, DUTY_MAX) and rate = req_rate.
REQ-020 err SHALL pulse high on the cycle after a handshake in which req_target > DUTY_MAX.
REQ-021 After a handshake the next state SHALL be:
- DONE if tgt == duty_out;
- WAIT_PERIOD if rate == 0;
- WAIT_TICK otherwise, with the timer loaded to rate.
REQ-022 WAIT_TICK SHALL decrement the timer every cycle and go to WAIT_PERIOD on the edge where the timer equals 1, giving exactly rate cycles in WAIT_TICK.
REQ-023 period_end SHALL be ignored outside WAIT_PERIOD.
REQ-024 In WAIT_PERIOD with period_end=1, duty_out SHALL step by ±1 toward tgt on that same edge.
REQ-025 After a step, the next state SHALL be DONE if the new duty equals tgt; otherwise WAIT_TICK with the timer reloaded, or WAIT_PERIOD if rate == 0.
REQ-026 duty_out SHALL change only per REQ-024, so each update coincides with a period boundary and at most one step occurs per PWM period.
REQ-027 duty_out SHALL never leave the range 0..DUTY_MAX; there is no wrap-around in either direction.
REQ-028 DONE SHALL last one cycle with done=1, then return to IDLE; a request cannot be accepted while in DONE.
REQ-029 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, hold duty_out, and suppress done.
REQ-030 abort=1 together with period_end=1 SHALL take priority: no step occurs. abort in IDLE SHALL be ignored.
REQ-031 busy SHALL be 1 in WAIT_TICK, WAIT_PERIOD and DONE, and 0 in IDLE.

Reset
REQ-032 While rst_n=0 the block SHALL hold: state IDLE, duty_out=DUTY_INIT, timer=0, tgt=DUTY_INIT, busy=0, done=0, err=0, req_ready=0.
REQ-033 req_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-034 Reset asserted mid-ramp SHALL discard the ramp; no done or err pulse follows.

Structure
REQ-035 Package pwm_pkg SHALL hold DUTY_W, DUTY_MAX and DUTY_INIT defaults plus the FSM state enumeration, shared with the PWM datapath.
REQ-036 The rate timer SHALL be a sub-module pwm_rate_timer with load, load value, decrement and expire outputs; everything else stays in pwm_ramp_ctrl.

Verification
REQ-037 Up ramp: reset, target=8, rate=3, period_end every 10 cycles -> duty_out goes 5→6→7→8, one step per period_end, then done pulses once and busy=0.
REQ-038 Jump at rate 0: target=2, rate=0 -> duty_out decrements at three consecutive period_end pulses, steps 4, 3, 2, then done.
REQ-039 Clamp: target=15 -> err pulses the cycle after the handshake; duty_out ramps to 10 and never exceeds 10.
REQ-040 No-op request: target=5 from reset -> DONE on the next cycle, done pulses, duty_out stays 5, no step.
REQ-041 Abort: abort asserted in the same cycle as period_end while at duty 7 ramping to 9 -> duty_out stays 7, IDLE next cycle, no done.
REQ-042 Reset mid-ramp: rst_n low during WAIT_TICK -> duty_out=5, busy=0 immediately; req_ready=1 after release.
